// File: rtl/riscv_idu_ctrl.sv
// Decode-stage sequencer: in-order packet queue between IFU and IDU with
// valid/ready on both sides, redirect flush and halt/drain control.
module riscv_idu_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ifu_vld,
  output logic                       ifu_rdy,
  input  logic [DATA_W-1:0]          ifu_data,
  output logic                       idu_vld,
  input  logic                       idu_rdy,
  output logic [DATA_W-1:0]          idu_data,
  input  logic                       flush,
  input  logic                       halt_req,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  // Intake depends only on registered state, never on idu_rdy.
  assign ifu_rdy   = (r_state == RUN) && (r_count < CW'(DEPTH)) && !reset;
  assign idu_vld   = (r_count != '0) && (r_state != FLUSH) && !reset;
  assign idu_data  = r_mem[r_rd_ptr];
  assign halted    = (r_state == HALT) && !reset;
  assign occupancy = reset ? '0 : r_count;

  assign w_push = ifu_vld && ifu_rdy;
  assign w_pop  = idu_vld && idu_rdy;

  // NOTE: storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= ifu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= RUN;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      // Redirect wins over everything; any handshake this cycle is dropped.
      r_state  <= FLUSH;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      unique case (r_state)
        RUN:   if (halt_req) r_state <= DRAIN;
        FLUSH: r_state <= halt_req ? DRAIN : RUN;
        DRAIN: begin
          if (!halt_req)
            r_state <= RUN;
          else if ((r_count == '0) || ((r_count == CW'(1)) && w_pop))
            r_state <= HALT;
        end
        HALT:  if (!halt_req) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_idu_ctrl.sv
// Directed self-checking bench for riscv_idu_ctrl (DEPTH=4, DATA_W=64).
module tb_riscv_idu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_vld;
  logic        ifu_rdy;
  logic [63:0] ifu_data;
  logic        idu_vld;
  logic        idu_rdy;
  logic [63:0] idu_data;
  logic        flush;
  logic        halt_req;
  logic        halted;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  riscv_idu_ctrl #(.DEPTH(4), .DATA_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .ifu_vld   (ifu_vld),
    .ifu_rdy   (ifu_rdy),
    .ifu_data  (ifu_data),
    .idu_vld   (idu_vld),
    .idu_rdy   (idu_rdy),
    .idu_data  (idu_data),
    .flush     (flush),
    .halt_req  (halt_req),
    .halted    (halted),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  // Packet i: pc = 0x1000 + 4*i, instr = 0x13 + 0x80*i
  function automatic logic [63:0] pk(input int i);
    logic [31:0] pc;
    logic [31:0] ins;
    pc  = 32'h1000 + 32'(4 * i);
    ins = 32'h13 + 32'(128 * i);
    return {pc, ins};
  endfunction

  // Inputs change just after a negedge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; ifu_vld = 0; ifu_data = '0; idu_rdy = 0; flush = 0; halt_req = 0;
    @(negedge clock); #1;
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b000_000) begin
      $display("FAIL reset_asserted got rdy=%b vld=%b halted=%b occ=%0d want 0/0/0/0",
               ifu_rdy, idu_vld, halted, occupancy);
      bad++;
    end
    tick();
    reset = 0; #1;
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b100_000) begin
      $display("FAIL reset_released got rdy=%b vld=%b halted=%b occ=%0d want 1/0/0/0",
               ifu_rdy, idu_vld, halted, occupancy);
      bad++;
    end
  endtask

  task automatic test_basic();
    idu_rdy = 1;
    ifu_vld = 1; ifu_data = pk(0); #1;
    total++;
    if ({ifu_rdy, idu_vld} !== 2'b10) begin
      $display("FAIL basic_first_push got rdy=%b vld=%b want 1/0", ifu_rdy, idu_vld);
      bad++;
    end
    tick();
    ifu_data = pk(1); #1;
    total++;
    if (idu_vld !== 1'b1 || idu_data !== 64'h0000_1000_0000_0013 || occupancy !== 3'd1) begin
      $display("FAIL basic_pkt0 got vld=%b data=%h occ=%0d want 1/0000100000000013/1",
               idu_vld, idu_data, occupancy);
      bad++;
    end
    tick();
    ifu_vld = 0; #1;
    total++;
    if (idu_vld !== 1'b1 || idu_data !== 64'h0000_1004_0000_0093 || occupancy !== 3'd1) begin
      $display("FAIL basic_pkt1 got vld=%b data=%h occ=%0d want 1/0000100400000093/1",
               idu_vld, idu_data, occupancy);
      bad++;
    end
    tick();
    total++;
    if (idu_vld !== 1'b0 || occupancy !== 3'd0) begin
      $display("FAIL basic_empty got vld=%b occ=%0d want 0/0", idu_vld, occupancy);
      bad++;
    end
  endtask

  task automatic test_fill();
    idu_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      ifu_vld = 1; ifu_data = pk(10 + i); #1;
      total++;
      if (ifu_rdy !== (i < 4)) begin
        $display("FAIL fill_rdy[%0d] got %b want %b", i, ifu_rdy, (i < 4));
        bad++;
      end
      tick();
    end
    ifu_vld = 0; #1;
    total++;
    if (occupancy !== 3'd4 || ifu_rdy !== 1'b0 || idu_vld !== 1'b1 || idu_data !== pk(10)) begin
      $display("FAIL fill_full got occ=%0d rdy=%b vld=%b data=%h want 4/0/1/%h",
               occupancy, ifu_rdy, idu_vld, idu_data, pk(10));
      bad++;
    end
    idu_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (idu_vld !== 1'b1 || idu_data !== pk(10 + i) || ifu_rdy !== (i != 0)) begin
        $display("FAIL fill_pop[%0d] got vld=%b data=%h rdy=%b want 1/%h/%b",
                 i, idu_vld, idu_data, ifu_rdy, pk(10 + i), (i != 0));
        bad++;
      end
      tick();
    end
    total++;
    if (idu_vld !== 1'b0 || occupancy !== 3'd0) begin
      $display("FAIL fill_drained got vld=%b occ=%0d want 0/0", idu_vld, occupancy);
      bad++;
    end
  endtask

  task automatic test_flush();
    idu_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      ifu_vld = 1; ifu_data = pk(20 + i); tick();
    end
    flush = 1; ifu_data = pk(29); #1;
    total++;
    if (occupancy !== 3'd3) begin
      $display("FAIL flush_pre_occ got %0d want 3", occupancy);
      bad++;
    end
    tick();
    flush = 0; ifu_data = pk(23); #1;
    total++;
    if ({ifu_rdy, idu_vld, occupancy} !== 5'b00_000) begin
      $display("FAIL flush_state got rdy=%b vld=%b occ=%0d want 0/0/0",
               ifu_rdy, idu_vld, occupancy);
      bad++;
    end
    tick();
    total++;
    if (ifu_rdy !== 1'b1) begin
      $display("FAIL flush_resume_rdy got %b want 1", ifu_rdy);
      bad++;
    end
    tick();
    ifu_vld = 0; idu_rdy = 1; #1;
    total++;
    if (idu_vld !== 1'b1 || idu_data !== pk(23) || occupancy !== 3'd1) begin
      $display("FAIL flush_next_pkt got vld=%b data=%h occ=%0d want 1/%h/1",
               idu_vld, idu_data, occupancy, pk(23));
      bad++;
    end
    tick();
    total++;
    if (idu_vld !== 1'b0 || occupancy !== 3'd0) begin
      $display("FAIL flush_empty got vld=%b occ=%0d want 0/0", idu_vld, occupancy);
      bad++;
    end
    idu_rdy = 0;
  endtask

  task automatic test_halt();
    idu_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      ifu_vld = 1; ifu_data = pk(30 + i); tick();
    end
    ifu_vld = 0; halt_req = 1; idu_rdy = 1; #1;
    total++;
    if (idu_vld !== 1'b1 || idu_data !== pk(30) || halted !== 1'b0) begin
      $display("FAIL halt_pop0 got vld=%b data=%h halted=%b want 1/%h/0",
               idu_vld, idu_data, halted, pk(30));
      bad++;
    end
    tick();
    ifu_vld = 1; ifu_data = pk(39); #1;
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b010_001 || idu_data !== pk(31)) begin
      $display("FAIL halt_drain got rdy=%b vld=%b halted=%b occ=%0d data=%h want 0/1/0/1/%h",
               ifu_rdy, idu_vld, halted, occupancy, idu_data, pk(31));
      bad++;
    end
    tick();
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b001_000) begin
      $display("FAIL halt_halted got rdy=%b vld=%b halted=%b occ=%0d want 0/0/1/0",
               ifu_rdy, idu_vld, halted, occupancy);
      bad++;
    end
    tick();
    ifu_vld = 0; halt_req = 0; #1;
    total++;
    if (halted !== 1'b1 || occupancy !== 3'd0) begin
      $display("FAIL halt_hold got halted=%b occ=%0d want 1/0", halted, occupancy);
      bad++;
    end
    tick();
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b100_000) begin
      $display("FAIL halt_release got rdy=%b vld=%b halted=%b occ=%0d want 1/0/0/0",
               ifu_rdy, idu_vld, halted, occupancy);
      bad++;
    end
    idu_rdy = 0;
  endtask

  task automatic test_full_both();
    idu_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      ifu_vld = 1; ifu_data = pk(40 + i); tick();
    end
    ifu_data = pk(44); idu_rdy = 1; #1;
    total++;
    if (ifu_rdy !== 1'b0 || idu_vld !== 1'b1 || idu_data !== pk(40)) begin
      $display("FAIL full_both got rdy=%b vld=%b data=%h want 0/1/%h",
               ifu_rdy, idu_vld, idu_data, pk(40));
      bad++;
    end
    tick();
    ifu_vld = 0; idu_rdy = 0; #1;
    total++;
    if (occupancy !== 3'd3 || idu_data !== pk(41)) begin
      $display("FAIL full_both_after got occ=%0d data=%h want 3/%h",
               occupancy, idu_data, pk(41));
      bad++;
    end
    idu_rdy = 1;
    for (int i = 1; i < 4; i++) begin
      #1;
      total++;
      if (idu_vld !== 1'b1 || idu_data !== pk(40 + i)) begin
        $display("FAIL full_both_pop[%0d] got vld=%b data=%h want 1/%h",
                 i, idu_vld, idu_data, pk(40 + i));
        bad++;
      end
      tick();
    end
    total++;
    if (idu_vld !== 1'b0 || occupancy !== 3'd0) begin
      $display("FAIL full_both_empty got vld=%b occ=%0d want 0/0", idu_vld, occupancy);
      bad++;
    end
    idu_rdy = 0;
  endtask

  task automatic test_reset_mid();
    idu_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      ifu_vld = 1; ifu_data = pk(50 + i); tick();
    end
    reset = 1; ifu_vld = 1; ifu_data = pk(59); idu_rdy = 1; #1;
    total++;
    if ({ifu_rdy, idu_vld, occupancy} !== 5'b00_000) begin
      $display("FAIL rst_mid_during got rdy=%b vld=%b occ=%0d want 0/0/0",
               ifu_rdy, idu_vld, occupancy);
      bad++;
    end
    tick();
    reset = 0; ifu_vld = 0; #1;
    total++;
    if ({ifu_rdy, idu_vld, halted, occupancy} !== 6'b100_000) begin
      $display("FAIL rst_mid_after got rdy=%b vld=%b halted=%b occ=%0d want 1/0/0/0",
               ifu_rdy, idu_vld, halted, occupancy);
      bad++;
    end
    tick();
    total++;
    if (idu_vld !== 1'b0 || occupancy !== 3'd0) begin
      $display("FAIL rst_mid_stale got vld=%b occ=%0d want 0/0", idu_vld, occupancy);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_halt();
    test_full_both();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_idu_ctrl.md
Name: riscv_idu_ctrl

Overview:
Decode-stage sequencer between the IFU and the IDU. It buffers fetched instruction packets in a small in-order queue and applies valid/ready handshakes on both sides. It handles pipeline flush (redirect) and halt/drain requests, so the IDU only sees valid, non-stale instructions.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
DATA_W, 64, packet width ({pc[31:0], instr[31:0]})

Ports:
clock  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
ifu_vld  input  1  IFU packet valid
ifu_rdy  output  1  controller accepts IFU packet
ifu_data  input  DATA_W  IFU packet
idu_vld  output  1  packet valid to IDU
idu_rdy  input  1  IDU accepts packet
idu_data  output  DATA_W  head-of-queue packet
flush  input  1  redirect; discard everything buffered
halt_req  input  1  stop fetch intake and drain queue
halted  output  1  queue empty and intake stopped
occupancy  output  $clog2(DEPTH)+1  current entry count

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high. All state updates on posedge clock.
- Reset: count=0, rd/wr ptrs=0, state=RUN. While reset=1: ifu_rdy=0, idu_vld=0, halted=0, occupancy=0. Queue storage is not reset.
- push = ifu_vld & ifu_rdy; pop = idu_vld & idu_rdy.
- ifu_rdy = (state==RUN) & (count<DEPTH) & !reset. There is no combinational path from idu_rdy to ifu_rdy. When full, no push occurs in the same cycle as a pop.
- idu_vld = (count!=0) & (state!=FLUSH) & !reset. idu_data is the entry at rd_ptr and must be stable while idu_vld=1 and idu_rdy=0.
- Simultaneous push and pop: count is unchanged and both ptrs advance. Ptrs wrap modulo DEPTH.
- Packets reach the IDU in push order. Minimum latency is 1 cycle: a packet pushed in cycle N can be popped in cycle N+1.
- States: RUN, FLUSH, DRAIN, HALT.
  - RUN: flush -> FLUSH; else halt_req -> DRAIN.
  - FLUSH (exactly 1 cycle; ifu_rdy=0, idu_vld=0): flush -> FLUSH; else halt_req -> DRAIN; else RUN.
  - DRAIN (ifu_rdy=0, pops allowed): flush -> FLUSH; else !halt_req -> RUN; else (count==0, or count==1 & pop) -> HALT.
  - HALT (ifu_rdy=0, idu_vld=0, halted=1): flush -> FLUSH; else !halt_req -> RUN.
- Flush has highest priority. On a flush edge, count and both ptrs become 0. A push or pop in the flush cycle is discarded and does not count.
- halted = (state==HALT). It deasserts in the cycle after halt_req falls.
- occupancy = count (registered).
- Invariants:
  - 0 <= count <= DEPTH.
  - No push when count==DEPTH.
  - No pop when count==0.
  - When idu_vld=1, idu_data contains no X/Z bits.

Test Plan:
- Reset, then push 0x1000/0x13, 0x1004/0x93 with idu_rdy=1 -> idu_vld rises 1 cycle after each push; packets arrive in order; occupancy returns to 0.
- idu_rdy=0 and push 5 packets with DEPTH=4 -> ifu_rdy drops after the 4th; occupancy=4; idu_data holds packet 0. Then idu_rdy=1 -> 4 pops in order, and ifu_rdy rises the cycle after the first pop.
- Fill 3 entries, then assert flush for 1 cycle together with ifu_vld -> next cycle occupancy=0, state=FLUSH, ifu_rdy=0, idu_vld=0. The following cycle ifu_rdy=1, and the flushed-cycle packet never appears.
- 2 entries queued, halt_req=1, idu_rdy=1 -> ifu_rdy=0 immediately; 2 pops; halted=1 the cycle after the last pop. halt_req=0 -> halted=0 and ifu_rdy=1 next cycle.
- Full queue with ifu_vld=1 and idu_rdy=1 in the same cycle -> exactly one pop and no push; occupancy=3 next cycle.
- Assert reset mid-stream with 2 entries queued -> ifu_rdy=0 and idu_vld=0 during reset; occupancy=0 and state=RUN after reset; no stale packet is emitted.
